// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM states, bus flag positions
// and the SSRAM word format (37 bits with MEMRSP_PARITY_EN defined, else 36).
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RDWAIT = 3'd1,
        ST_RDACK  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_WRACK  = 3'd4,
        ST_LOCKED = 3'd5
    } state_t;

    // Bus words are numbered [0:35] with bit 0 as the most significant bit.
    localparam int BUS_W         = 36;
    localparam int BUS_READ_BIT  = 3;
    localparam int BUS_WRITE_BIT = 5;
    localparam int BUS_IO_BIT    = 10;
    localparam int BUS_ADDR_MSB  = 16;
    localparam int BUS_ADDR_LSB  = 35;
    localparam int BUS_AWIDTH    = BUS_ADDR_LSB - BUS_ADDR_MSB + 1;

    localparam int LAT_W = 3;

`ifdef MEMRSP_PARITY_EN
    localparam int SSRAM_DW = BUS_W + 1;
`else
    localparam int SSRAM_DW = BUS_W;
`endif

    // Even parity bit: makes the total count of ones in data+parity even.
    function automatic logic even_parity(input logic [0:BUS_W-1] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_latency_ctr.sv
// Loadable down-counter that times the SSRAM read latency; o_zero marks the
// clock in which read data is valid on the SSRAM pins.
module mem_latency_ctr #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_responder.sv
// Memory bus target: decodes read/write/read-modify-write cycles and runs them
// against a synchronous SRAM. MEMRSP_PARITY_EN adds a stored parity bit and memPERR.
module mem_responder
    import mem_pkg::*;
#(
    parameter int MEM_AWIDTH  = 20,
    parameter int MEM_WORDS   = 1048576,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  busREQI,
    input  logic [0:BUS_W-1]      busADDRI,
    input  logic [0:BUS_W-1]      busDATAI,
    output logic                  busACKO,
    output logic [0:BUS_W-1]      busDATAO,
    output logic [MEM_AWIDTH-1:0] ssramADDR,
    output logic                  ssramWR,
    output logic [0:SSRAM_DW-1]   ssramDO,
    input  logic [0:SSRAM_DW-1]   ssramDI,
`ifdef MEMRSP_PARITY_EN
    output logic                  memPERR,
`endif
    output logic                  memBUSY,
    output state_t                o_dbg_state
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY);

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    state_t                r_state;
    logic                  r_lock;
    logic [BUS_AWIDTH-1:0] r_addr;
`ifdef MEMRSP_PARITY_EN
    logic                  r_par_bad;
`endif

    logic                  w_rd;
    logic                  w_wr;
    logic                  w_io;
    logic [BUS_AWIDTH-1:0] w_word_addr;
    logic                  w_in_range;
    logic                  w_req_ok;
    logic                  w_unlock_wr;
    logic                  w_lat_load;
    logic                  w_lat_dec;
    logic                  w_lat_zero;

    assign w_rd        = busADDRI[BUS_READ_BIT];
    assign w_wr        = busADDRI[BUS_WRITE_BIT];
    assign w_io        = busADDRI[BUS_IO_BIT];
    assign w_word_addr = busADDRI[BUS_ADDR_MSB:BUS_ADDR_LSB];
    assign w_in_range  = 32'(w_word_addr) < 32'(MEM_WORDS);

    // Requests are ignored while an ack is on the bus: the initiator still
    // holds busREQI in that clock and must drop it before the next cycle.
    assign w_req_ok    = busREQI && !w_io && w_in_range && !busACKO;
    assign w_unlock_wr = w_req_ok && w_wr && !w_rd && (w_word_addr == r_addr);

    assign w_lat_load  = (r_state == ST_IDLE) && w_req_ok && w_rd;
    assign w_lat_dec   = (r_state == ST_RDWAIT);

    mem_latency_ctr #(
        .W(LAT_W)
    ) u_lat_ctr (
        .i_clk      (clk),
        .i_rst_n    (w_rst_n),
        .i_load     (w_lat_load),
        .i_load_val (LAT_LOAD),
        .i_dec      (w_lat_dec),
        .o_zero     (w_lat_zero)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= ST_IDLE;
            r_lock    <= 1'b0;
            r_addr    <= '0;
            busACKO   <= 1'b0;
            busDATAO  <= '0;
            ssramADDR <= '0;
            ssramWR   <= 1'b0;
            ssramDO   <= '0;
            memBUSY   <= 1'b0;
`ifdef MEMRSP_PARITY_EN
            r_par_bad <= 1'b0;
            memPERR   <= 1'b0;
`endif
        end else begin
            busACKO <= 1'b0;
            ssramWR <= 1'b0;
`ifdef MEMRSP_PARITY_EN
            memPERR <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_req_ok && (w_rd || w_wr)) begin
                        r_addr    <= w_word_addr;
                        ssramADDR <= MEM_AWIDTH'(w_word_addr);
                        r_lock    <= w_rd && w_wr;
                        memBUSY   <= 1'b1;
                        r_state   <= w_rd ? ST_RDWAIT : ST_WRITE;
                    end
                end

                ST_RDWAIT: begin
                    if (!busREQI) begin
                        r_state <= ST_IDLE;
                        r_lock  <= 1'b0;
                        memBUSY <= 1'b0;
                    end else if (w_lat_zero) begin
                        busDATAO  <= ssramDI[0:BUS_W-1];
`ifdef MEMRSP_PARITY_EN
                        r_par_bad <= even_parity(ssramDI[0:BUS_W-1]) != ssramDI[BUS_W];
`endif
                        r_state   <= ST_RDACK;
                    end
                end

                ST_RDACK: begin
                    if (!busREQI) begin
                        r_state <= ST_IDLE;
                        r_lock  <= 1'b0;
                        memBUSY <= 1'b0;
                    end else begin
                        busACKO <= 1'b1;
`ifdef MEMRSP_PARITY_EN
                        memPERR <= r_par_bad;
`endif
                        // A read-modify-write holds the bus target until its write half arrives.
                        r_state <= r_lock ? ST_LOCKED : ST_IDLE;
                        memBUSY <= r_lock;
                    end
                end

                ST_WRITE: begin
                    if (!busREQI) begin
                        r_state <= ST_IDLE;
                        r_lock  <= 1'b0;
                        memBUSY <= 1'b0;
                    end else begin
                        ssramWR <= 1'b1;
`ifdef MEMRSP_PARITY_EN
                        ssramDO <= {busDATAI, even_parity(busDATAI)};
`else
                        ssramDO <= busDATAI;
`endif
                        r_state <= ST_WRACK;
                    end
                end

                ST_WRACK: begin
                    r_state <= ST_IDLE;
                    memBUSY <= 1'b0;
                    if (busREQI) begin
                        busACKO <= 1'b1;
                    end
                end

                ST_LOCKED: begin
                    if (w_unlock_wr) begin
                        r_lock  <= 1'b0;
                        r_state <= ST_WRITE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_lock  <= 1'b0;
                    memBUSY <= 1'b0;
                end
            endcase
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder with a behavioural SSRAM model and a
// read-data scoreboard; build with +define+MEMRSP_PARITY_EN for the parity cases.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int AW    = 20;
    localparam int WORDS = 1024;
    localparam int LAT   = 2;
`ifdef MEMRSP_PARITY_EN
    localparam int DW = 37;
`else
    localparam int DW = 36;
`endif

    logic            clk;
    logic            rst;
    logic            busREQI;
    logic [0:35]     busADDRI;
    logic [0:35]     busDATAI;
    logic            busACKO;
    logic [0:35]     busDATAO;
    logic [AW-1:0]   ssramADDR;
    logic            ssramWR;
    logic [0:DW-1]   ssramDO;
    logic [0:DW-1]   ssramDI;
`ifdef MEMRSP_PARITY_EN
    logic            memPERR;
`endif
    logic            memBUSY;
    state_t          dbg_state;

    mem_responder #(
        .MEM_AWIDTH (AW),
        .MEM_WORDS  (WORDS),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .busREQI    (busREQI),
        .busADDRI   (busADDRI),
        .busDATAI   (busDATAI),
        .busACKO    (busACKO),
        .busDATAO   (busDATAO),
        .ssramADDR  (ssramADDR),
        .ssramWR    (ssramWR),
        .ssramDO    (ssramDO),
        .ssramDI    (ssramDI),
`ifdef MEMRSP_PARITY_EN
        .memPERR    (memPERR),
`endif
        .memBUSY    (memBUSY),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- SSRAM model ----------------
    logic [0:DW-1] mem [0:WORDS-1];
    logic [0:DW-1] pipe [0:LAT-1];
    logic          bd_we = 1'b0;
    logic [9:0]    bd_addr = '0;
    logic [0:DW-1] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ssramWR) mem[ssramADDR[9:0]] <= ssramDO;
        pipe[0] <= mem[ssramADDR[9:0]];
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign ssramDI = pipe[LAT-1];

    function automatic logic [0:DW-1] mk_word(input logic [35:0] d);
`ifdef MEMRSP_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [35:0] exp_q[$];
    logic        exp_perr_q[$];
    logic        exp_kind_q[$];   // 1 = read ack, 0 = write ack

    initial begin : monitor
        logic        k;
        logic [35:0] d;
        logic        p;
        forever begin
            @(negedge clk);
            if (busACKO) begin
                if (exp_kind_q.size() == 0) begin
                    chk("ack_unexpected", 64'd1, 64'd0);
                end else begin
                    k = exp_kind_q.pop_front();
                    if (k) begin
                        d = exp_q.pop_front();
                        p = exp_perr_q.pop_front();
                        chk("rd_data", 64'(busDATAO), 64'(d));
`ifdef MEMRSP_PARITY_EN
                        chk("rd_perr", 64'(memPERR), 64'(p));
`endif
                    end
                end
            end
`ifdef MEMRSP_PARITY_EN
            if (!busACKO && memPERR) chk("perr_without_ack", 64'd1, 64'd0);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [9:0] a, input logic [0:DW-1] w);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = w;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic drive_req(input logic rd, input logic wr, input logic io,
                             input logic [19:0] a, input logic [35:0] d);
        logic [0:35] w;
        w = '0;
        w[3] = rd; w[5] = wr; w[10] = io; w[16:35] = a;
        busADDRI = w;
        busDATAI = d;
        busREQI  = 1'b1;
    endtask

    // Runs one acknowledged cycle; latency counted from the sampling edge.
    task automatic bus_cycle(input string tag, input logic rd, input logic wr,
                             input logic [19:0] a, input logic [35:0] d,
                             input int exp_lat, output int wr_seen, output int wr_at);
        int  c0, lat;
        bit  got;
        @(negedge clk);
        drive_req(rd, wr, 1'b0, a, d);
        c0 = cyc; got = 0; lat = -1; wr_seen = 0; wr_at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ssramWR) begin
                wr_seen++;
                wr_at = cyc - c0 - 1;
            end
            if (busACKO) begin
                got = 1;
                lat = cyc - c0 - 1;
                break;
            end
        end
        busREQI = 1'b0;
        chk({tag, "_ack_seen"}, 64'(got), 64'd1);
        chk({tag, "_ack_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic do_read(input string tag, input logic [19:0] a,
                           input logic [35:0] exp_d, input logic exp_p);
        int ws, wa;
        exp_kind_q.push_back(1'b1);
        exp_q.push_back(exp_d);
        exp_perr_q.push_back(exp_p);
        bus_cycle(tag, 1'b1, 1'b0, a, '0, LAT + 2, ws, wa);
        chk({tag, "_no_strobe"}, 64'(ws), 64'd0);
    endtask

    task automatic do_write(input string tag, input logic [19:0] a, input logic [35:0] d);
        int ws, wa;
        logic [0:DW-1] w;
        exp_kind_q.push_back(1'b0);
        bus_cycle(tag, 1'b0, 1'b1, a, d, 2, ws, wa);
        chk({tag, "_strobe_count"}, 64'(ws), 64'd1);
        chk({tag, "_strobe_at"}, 64'(wa), 64'd1);
        @(negedge clk);
        w = mem[a[9:0]];
        chk({tag, "_stored"}, 64'(w), 64'(mk_word(d)));
    endtask

    // Holds a request that must never be acknowledged.
    task automatic hold_no_ack(input string tag, input logic rd, input logic wr, input logic io,
                               input logic [19:0] a, input int cycles, input bit busy_must_be_low);
        int acks, busy_hits;
        @(negedge clk);
        drive_req(rd, wr, io, a, 36'h5A5A5A5A5);
        acks = 0; busy_hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busACKO) acks++;
            if (memBUSY) busy_hits++;
        end
        busREQI = 1'b0;
        chk({tag, "_no_ack"}, 64'(acks), 64'd0);
        if (busy_must_be_low) chk({tag, "_busy_low"}, 64'(busy_hits), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"},   64'(busACKO),   64'd0);
        chk({tag, "_data"},  64'(busDATAO),  64'd0);
        chk({tag, "_wr"},    64'(ssramWR),   64'd0);
        chk({tag, "_addr"},  64'(ssramADDR), 64'd0);
        chk({tag, "_do"},    64'(ssramDO),   64'd0);
        chk({tag, "_busy"},  64'(memBUSY),   64'd0);
        chk({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
`ifdef MEMRSP_PARITY_EN
        chk({tag, "_perr"},  64'(memPERR),   64'd0);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [63:0] rnd;
        logic [35:0] d;
        logic [19:0] a;
        int          acks;
        int          ws, wa;

        rst = 1'b0; busREQI = 1'b0; busADDRI = '0; busDATAI = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Plain read with known contents
        preload(10'h010, mk_word(36'o123456701234));
        do_read("read_0x10", 20'h00010, 36'o123456701234, 1'b0);
        chk("read_0x10_ssram_addr", 64'(ssramADDR), 64'h10);
        chk("read_0x10_state_after", 64'(dbg_state), 64'(ST_IDLE));

        // Write then read back
        do_write("write_0x20", 20'h00020, 36'o777777000000);
        do_read("readback_0x20", 20'h00020, 36'o777777000000, 1'b0);

        // Read-modify-write locks the target until the matching write
        preload(10'h030, mk_word(36'o252525252525));
        exp_kind_q.push_back(1'b1);
        exp_q.push_back(36'o252525252525);
        exp_perr_q.push_back(1'b0);
        bus_cycle("rmw_0x30", 1'b1, 1'b1, 20'h00030, '0, LAT + 2, ws, wa);
        chk("rmw_state_locked", 64'(dbg_state), 64'(ST_LOCKED));
        hold_no_ack("locked_read_0x40", 1'b1, 1'b0, 1'b0, 20'h00040, 20, 1'b0);
        chk("locked_still", 64'(dbg_state), 64'(ST_LOCKED));
        hold_no_ack("locked_write_other", 1'b0, 1'b1, 1'b0, 20'h00031, 6, 1'b0);
        do_write("unlock_write_0x30", 20'h00030, 36'o101010101010);
        chk("unlock_state_idle", 64'(dbg_state), 64'(ST_IDLE));

        // Never-acknowledged requests
        hold_no_ack("io_read", 1'b1, 1'b0, 1'b1, 20'h00010, 50, 1'b1);
        hold_no_ack("out_of_range", 1'b1, 1'b0, 1'b0, 20'd1024, 50, 1'b1);
        hold_no_ack("no_flags", 1'b0, 1'b0, 1'b0, 20'h00010, 20, 1'b1);

        // Random write/readback pairs
        for (int i = 0; i < 6; i++) begin
            rnd = {$urandom, $urandom};
            d   = rnd[35:0];
            a   = 20'($urandom_range(16'h060, WORDS - 1));
            do_write("rand_write", a, d);
            do_read("rand_read", a, d, 1'b0);
        end

        // Request dropped one clock into RDWAIT
        @(negedge clk);
        drive_req(1'b1, 1'b0, 1'b0, 20'h00010, '0);
        @(negedge clk);
        busREQI = 1'b0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busACKO) acks++;
        end
        chk("abandon_no_ack", 64'(acks), 64'd0);
        chk("abandon_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("abandon_busy", 64'(memBUSY), 64'd0);

        // Reset in the middle of a read
        @(negedge clk);
        drive_req(1'b1, 1'b0, 1'b0, 20'h00020, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_read_reset");
        busREQI = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        do_read("after_reset_read", 20'h00010, 36'o123456701234, 1'b0);

`ifdef MEMRSP_PARITY_EN
        // Stored parity bit flipped: data returned, memPERR with the ack
        d = 36'o112233445566;
        preload(10'h050, {d, ~(^d)});
        do_read("parity_bad_0x50", 20'h00050, d, 1'b1);
        do_read("parity_good_0x20", 20'h00020, 36'o777777000000, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_kind_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Bus target at the far end of the CPU memory/IO bus. Decodes a requested physical memory cycle (read, write, or read-modify-write), runs it against an external synchronous-SRAM word store, and returns the acknowledge and read data to the initiator. IO cycles and addresses outside the configured memory size are never acknowledged, so the initiator's non-existent-memory timeout handles them. Sits between the bus arbiter and the SSRAM pins.

## Interface
- MEM_AWIDTH, 20, physical word-address width used to address SSRAM.
- MEM_WORDS, 1048576, number of implemented words; addresses >= this are not acknowledged.
- MEM_LATENCY, 2, SSRAM read latency in clocks (1..7).
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low, synchronous release inside the block.
- busREQI  in  1  request; a level held by the initiator until busACKO.
- busADDRI  in  36  [0:35]; bit 3 READ, bit 5 WRITE, bit 10 IO, bits 16:35 word address.
- busDATAI  in  36  [0:35] write data, valid while busREQI is high.
- busACKO  out  1  one-clock acknowledge pulse.
- busDATAO  out  36  [0:35] read data, valid on busACKO, held until the next read ack.
- ssramADDR  out  MEM_AWIDTH  SSRAM word address.
- ssramWR  out  1  SSRAM write strobe, one clock per write.
- ssramDO  out  36 (37 with parity)  SSRAM write data.
- ssramDI  in  36 (37 with parity)  SSRAM read data.
- memBUSY  out  1  high whenever the state machine is not IDLE.

## Operation
- States: IDLE, RDWAIT, RDACK, WRITE, WRACK, LOCKED.
- IDLE: on busREQI & ~IO & address < MEM_WORDS, latch the address. READ -> RDWAIT. WRITE only -> WRITE. READ & WRITE (read-modify-write) -> RDWAIT with the lock flag set. Neither READ nor WRITE, IO, or out of range -> stay in IDLE and never ack.
- RDWAIT: counts MEM_LATENCY clocks from SSRAM address issue, then captures ssramDI into busDATAO -> RDACK.
- RDACK: busACKO=1 for one clock -> LOCKED if lock is set, else IDLE.
- WRITE: ssramWR=1, ssramDO=busDATAI -> WRACK; WRACK: busACKO=1 -> IDLE.
- LOCKED: only a WRITE-only request to the latched address is accepted (-> WRITE, lock cleared). Any other request waits unacknowledged. No timeout inside the block.
- Request deasserted before the ack: abandon the cycle and go to IDLE. A write already strobed is not undone.
- A new request is not sampled in the clock busACKO is high. The initiator must drop busREQI after the ack.
- Reset: state IDLE, lock clear, busACKO=0, busDATAO=0, ssramWR=0, ssramADDR=0, ssramDO=0, memBUSY=0.

## Timing
- Read: request sampled at edge N, ssramADDR driven from N. Data captured at N+MEM_LATENCY+1. busACKO high during clock N+MEM_LATENCY+2.
- Write: ssramWR high during clock N+1, busACKO high during clock N+2.
- Back-to-back: the next request is sampled no earlier than the clock after busACKO falls.
- All outputs are registered.

## Configuration
- MEMRSP_PARITY_EN defined:
  - SSRAM data is 37 bits; bit 36 is written as even parity of the data.
  - On read, a parity mismatch raises output memPERR for one clock, coincident with busACKO. The data is still returned and acked.
  - memPERR resets to 0.
- MEMRSP_PARITY_EN undefined: 36-bit SSRAM data, no memPERR port, no parity logic.

## Structure
- Shared package mem_pkg:
  - state enum.
  - bus flag bit-position constants (READ=3, WRITE=5, IO=10, address LSB range 16:35).
  - parity function.
- One natural sub-module, mem_latency_ctr: the loadable down-counter that times RDWAIT.

## Test plan
- Read at address 0x00010 with SSRAM preloaded to 0o123456701234, MEM_LATENCY=2 -> busACKO at request+4 clocks, busDATAO=0o123456701234.
- Write 0o777777000000 to 0x00020, then read it back -> ssramWR a single pulse at request+1, ack at request+2, readback matches.
- RMW at 0x00030 -> read acks and the block enters LOCKED.
  - A read of 0x00040 during LOCKED is not acked for 20 clocks.
  - A write to 0x00030 is acked at +2 and the block returns to IDLE.
- IO request (bit 10 set), and a read with MEM_WORDS=1024 at address 1024 -> no busACKO for 50 clocks, memBUSY stays 0.
- Deassert busREQI one clock into RDWAIT, and assert rst low mid-read -> no ack, state IDLE, all outputs at their reset values.
- With MEMRSP_PARITY_EN, flip SSRAM bit 36 at 0x00050 and read -> memPERR and busACKO in the same clock, data returned.
